// File: rtl/uart_byte_rx_pkg.sv
// uart_byte_rx_pkg: shared constants, receiver state encodings and a parity helper
// for the UART byte receiver.
package uart_byte_rx_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Receiver state encodings, kept as plain 3-bit constants so other blocks
  // (debug taps, status registers) can decode the state without the enum type.
  localparam logic [2:0] RX_ST_IDLE   = 3'd0;
  localparam logic [2:0] RX_ST_START  = 3'd1;
  localparam logic [2:0] RX_ST_DATA   = 3'd2;
  localparam logic [2:0] RX_ST_PARITY = 3'd3;
  localparam logic [2:0] RX_ST_STOP   = 3'd4;
  localparam logic [2:0] RX_ST_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    RX_IDLE   = RX_ST_IDLE,
    RX_START  = RX_ST_START,
    RX_DATA   = RX_ST_DATA,
    RX_PARITY = RX_ST_PARITY,
    RX_STOP   = RX_ST_STOP,
    RX_BREAK  = RX_ST_BREAK
  } rx_state_e;

  // Parity bit that a transmitter appends to data: even sense makes the total
  // count of ones even, odd sense makes it odd.
  function automatic logic parity_bit(input logic [UART_DATA_BITS-1:0] data,
                                      input logic                      odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: serial line plus the byte/strobe bundle handed to input_handler.
// master = receiver (consumes rx, produces bytes); slave = line driver / consumer.
interface uart_byte_rx_if;
  import uart_byte_rx_pkg::*;

  logic                      rx;
  logic [UART_DATA_BITS-1:0] byte_out;
  logic                      byte_available;
  logic                      framing_error;
  logic                      parity_error;
  logic                      busy;

  modport master (
    input  rx,
    output byte_out, byte_available, framing_error, parity_error, busy
  );

  modport slave (
    output rx,
    input  byte_out, byte_available, framing_error, parity_error, busy
  );

endinterface

// File: rtl/uart_byte_rx_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for a single asynchronous input.
// RST_VAL sets the value both flops take during reset (idle level of the line).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8-bit asynchronous UART receiver, LSB first, mid-bit sampling.
// Good bytes appear on byte_out with a one-cycle byte_available strobe; frames
// with a bad stop bit (or bad parity) are dropped and flagged with a strobe.
// Optional feature: define UART_RX_PARITY_EN for 8E1/8O1 (sense from PARITY_ODD);
// without it the receiver is 8N1 and parity_error is tied low.
module uart_byte_rx
  import uart_byte_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  uart_byte_rx_if.master bus
);

  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CLK_W-1:0] HALF_BIT = CLK_W'(CLKS_PER_BIT / 2);
  localparam logic [CLK_W-1:0] LAST_CLK = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_BITS - 1);

  logic rx_s;

  rx_state_e                 state_q,     state_d;
  logic [CLK_W-1:0]          clk_cnt_q,   clk_cnt_d;
  logic [BIT_W-1:0]          bit_cnt_q,   bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q,     shift_d;
  logic [UART_DATA_BITS-1:0] byte_out_q,  byte_out_d;
  logic                      byte_avl_q,  byte_avl_d;
  logic                      frame_err_q, frame_err_d;
  logic                      busy_q;
`ifdef UART_RX_PARITY_EN
  logic                      par_bad_q,   par_bad_d;
  logic                      par_err_q,   par_err_d;
`else
  logic                      unused_parity_odd;
`endif

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx),
    .q_o (rx_s)
  );

  // Next-state, datapath and strobe decode for the receive FSM.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + CLK_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_out_d  = byte_out_q;
    byte_avl_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif

    case (state_q)
      RX_IDLE: begin
        // Counter held at zero so the first START cycle sees count 0.
        clk_cnt_d = '0;
        if (!rx_s) begin
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end

      RX_START: begin
        if (clk_cnt_q == HALF_BIT) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          // A line back high at mid start bit was a glitch, not a frame.
          if (rx_s) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          state_d = RX_START;
        end
      end

      RX_DATA: begin
        if (clk_cnt_q == LAST_CLK) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          state_d = RX_DATA;
        end
      end

`ifdef UART_RX_PARITY_EN
      RX_PARITY: begin
        if (clk_cnt_q == LAST_CLK) begin
          clk_cnt_d = '0;
          par_bad_d = (rx_s != parity_bit(shift_q, PARITY_ODD));
          state_d   = RX_STOP;
        end else begin
          state_d = RX_PARITY;
        end
      end
`endif

      RX_STOP: begin
        if (clk_cnt_q == LAST_CLK) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            // Stop bit low: drop the byte and park until the line recovers.
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end else begin
            state_d = RX_IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              par_err_d = 1'b1;
            end else begin
              byte_out_d = shift_q;
              byte_avl_d = 1'b1;
            end
`else
            byte_out_d = shift_q;
            byte_avl_d = 1'b1;
`endif
          end
        end else begin
          state_d = RX_STOP;
        end
      end

      RX_BREAK: begin
        clk_cnt_d = '0;
        if (rx_s) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_BREAK;
        end
      end

      default: begin
        clk_cnt_d = '0;
        state_d   = RX_IDLE;
      end
    endcase
  end

  // FSM state, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_out_q  <= '0;
      byte_avl_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_out_q  <= byte_out_d;
      byte_avl_q  <= byte_avl_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != RX_IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity check result and parity error strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
    end
  end

  assign bus.parity_error = par_err_q;
`else
  assign bus.parity_error = 1'b0;
  assign unused_parity_odd = PARITY_ODD;
`endif

  assign bus.byte_out       = byte_out_q;
  assign bus.byte_available = byte_avl_q;
  assign bus.framing_error  = frame_err_q;
  assign bus.busy           = busy_q;

endmodule
